// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences CPU byte/halfword/word loads and stores onto a
// word-wide, big-endian data memory with a fixed read latency. Sub-word stores
// are done as read-modify-write. Illegal accesses (misaligned or beyond the
// memory) finish with err=1 and never touch the memory strobes.
module mem_access_unit #(
  parameter int SIZE_WORD = 2,
  parameter int ADDR_W    = $clog2(4 * SIZE_WORD),
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_read_data
);

  localparam int          CNT_W     = $clog2(RD_LAT + 1);
  localparam logic [31:0] MEM_BYTES = 32'(4 * SIZE_WORD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } op_e;

  state_e             state_q;
  op_e                op_q;
  logic [1:0]         off_q;
  logic [CNT_W-1:0]   rd_cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic [ADDR_W-1:0]  mem_address_q;
  logic [31:0]        mem_write_data_q;
  logic               mem_write_q;
  logic               mem_read_q;

  op_e  op_in;
  logic misaligned;
  logic acc_err;

  assign op_in = op_e'(op);

  // Pick the addressed lane out of a big-endian word and extend it per op.
  function automatic logic [31:0] extract_load(op_e lop, logic [1:0] off,
                                               logic [31:0] word);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    case (off)
      2'd0:    lane_b = word[31:24];
      2'd1:    lane_b = word[23:16];
      2'd2:    lane_b = word[15:8];
      default: lane_b = word[7:0];
    endcase
    lane_h = off[1] ? word[15:0] : word[31:16];
    case (lop)
      OP_LH:   extract_load = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  extract_load = {16'h0000, lane_h};
      OP_LB:   extract_load = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  extract_load = {24'h000000, lane_b};
      default: extract_load = word;
    endcase
  endfunction

  // Replace the addressed byte/halfword lane of the fetched word with store data.
  function automatic logic [31:0] merge_store(op_e sop, logic [1:0] off,
                                              logic [31:0] word,
                                              logic [31:0] sdata);
    merge_store = word;
    if (sop == OP_SH) begin
      if (off[1]) merge_store[15:0]  = sdata[15:0];
      else        merge_store[31:16] = sdata[15:0];
    end else begin
      case (off)
        2'd0:    merge_store[31:24] = sdata[7:0];
        2'd1:    merge_store[23:16] = sdata[7:0];
        2'd2:    merge_store[15:8]  = sdata[7:0];
        default: merge_store[7:0]   = sdata[7:0];
      endcase
    end
  endfunction

  // Legality check of the request presented in IDLE.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    misaligned = 1'b0;
    case (op_in)
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
    acc_err = misaligned || (addr >= MEM_BYTES);
  end

  // Access sequencer: state, latched request and all registered outputs.
  // NOTE: every output register is cleared by the asynchronous reset so the
  // strobes drop the moment rst_n falls, aborting any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      op_q             <= OP_LW;
      off_q            <= 2'b00;
      rd_cnt_q         <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      rdata_q          <= 32'h0;
      mem_address_q    <= '0;
      mem_write_data_q <= 32'h0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge value of every other one.
      case (state_q)
        S_IDLE: begin
          if (req) begin
            op_q          <= op_in;
            off_q         <= addr[1:0];
            mem_address_q <= {addr[ADDR_W-1:2], 2'b00};
            busy_q        <= 1'b1;
            if (acc_err) begin
              // done rises one edge later, via the settle cycle in S_DONE.
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else if (op_in == OP_SW) begin
              mem_write_data_q <= wdata;
              mem_write_q      <= 1'b1;
              state_q          <= S_WRITE;
            end else begin
              // Sub-word stores keep their data in mem_write_data_q until
              // the merge; it is only driven to memory with mem_write.
              mem_write_data_q <= wdata;
              mem_read_q       <= 1'b1;
              rd_cnt_q         <= CNT_W'(1);
              state_q          <= S_READ;
            end
          end
        end

        S_READ: begin
          if (rd_cnt_q == CNT_W'(RD_LAT)) begin
            mem_read_q <= 1'b0;
            if (op_q == OP_SH || op_q == OP_SB) begin
              mem_write_data_q <= merge_store(op_q, off_q, mem_read_data,
                                              mem_write_data_q);
              mem_write_q      <= 1'b1;
              state_q          <= S_WRITE;
            end else begin
              rdata_q <= extract_load(op_q, off_q, mem_read_data);
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            rd_cnt_q <= rd_cnt_q + CNT_W'(1);
          end
        end

        S_WRITE: begin
          mem_write_q <= 1'b0;
          done_q      <= 1'b1;
          state_q     <= S_DONE;
        end

        default: begin
          // Entered with done_q=0 only from a rejected access: spend one
          // cycle raising done so the error completes one edge after accept.
          if (done_q) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign rdata          = rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write      = mem_write_q;
  assign mem_read       = mem_read_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a two-word memory model beside the DUT, a
// scoreboard of expected completions pushed at request time and popped at
// done, and one task per scenario.
module tb_mem_access_unit;

  localparam int SIZE_WORD = 2;
  localparam int ADDR_W    = 3;
  localparam int RD_LAT    = 2;

  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                         LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wdat;
    logic        idx;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic [2:0]        op = 3'b000;
  logic [31:0]       addr = 32'h0;
  logic [31:0]       wdata = 32'h0;
  logic              busy, done, err, mem_write, mem_read;
  logic [31:0]       rdata, mem_write_data, mem_read_data;
  logic [ADDR_W-1:0] mem_address;

  logic [31:0] tb_mem [0:SIZE_WORD-1];
  logic [31:0] mdl_mem [0:SIZE_WORD-1];
  logic        load_mem = 1'b0;
  logic [31:0] last_rd = 32'h0;
  exp_t        sb[$];

  int n_tests = 0;
  int n_fail  = 0;
  int overlap_cnt = 0;
  int addr_change = 0;
  int done_total  = 0;
  int wr_total    = 0;
  logic              busy_prev = 1'b0;
  logic [ADDR_W-1:0] addr_prev = '0;

  mem_access_unit #(.SIZE_WORD(SIZE_WORD), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the strobe.
  assign mem_read_data = tb_mem[mem_address[2]];
  always @(posedge clk) begin
    if (load_mem) begin
      tb_mem[0] <= 32'h11223344;
      tb_mem[1] <= 32'hA0B0C0D0;
    end else if (mem_write) begin
      tb_mem[mem_address[2]] <= mem_write_data;
    end
  end

  // Global watchers: strobe overlap, address stability while busy, done/write counts.
  always @(negedge clk) begin
    if (rst_n && mem_read && mem_write) overlap_cnt++;
    if (rst_n && busy && busy_prev && mem_address !== addr_prev) addr_change++;
    if (rst_n && done) done_total++;
    if (rst_n && mem_write) wr_total++;
    busy_prev = busy;
    addr_prev = mem_address;
  end

  function automatic logic [31:0] ref_load(logic [2:0] o, logic [31:0] a, logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (3 - int'(a[1:0])))) & 32'h0000_00FF;
    h = (w >> (16 * (1 - int'(a[1])))) & 32'h0000_FFFF;
    case (o)
      LH:      return h[15] ? (h | 32'hFFFF_0000) : h;
      LHU:     return h;
      LB:      return b[7] ? (b | 32'hFFFF_FF00) : b;
      LBU:     return b;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(logic [2:0] o, logic [31:0] a,
                                            logic [31:0] w, logic [31:0] d);
    int          sh;
    logic [31:0] m;
    if (o == SH) begin
      sh = 16 * (1 - int'(a[1]));
      m  = 32'h0000_FFFF << sh;
    end else begin
      sh = 8 * (3 - int'(a[1:0]));
      m  = 32'h0000_00FF << sh;
    end
    return (w & ~m) | ((d << sh) & m);
  endfunction

  // Compute the expected completion from the model memory and queue it.
  task automatic push_exp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic bad;
    bad = (a >= 32'(4 * SIZE_WORD)) ||
          ((o == LW || o == SW) && a[1:0] != 2'b00) ||
          ((o == LH || o == LHU || o == SH) && a[0]);
    e.idx = a[2];
    e.err = bad;
    e.wdat = 32'h0;
    if (bad) begin
      e.lat = 1; e.rd = 0; e.wr = 0;
    end else if (o == SW) begin
      e.lat = 1; e.rd = 0; e.wr = 1; e.wdat = d;
    end else if (o == SH || o == SB) begin
      e.lat = RD_LAT + 1; e.rd = RD_LAT; e.wr = 1;
      e.wdat = ref_merge(o, a, mdl_mem[a[2]], d);
    end else begin
      e.lat = RD_LAT; e.rd = RD_LAT; e.wr = 0;
      last_rd = ref_load(o, a, mdl_mem[a[2]]);
    end
    if (e.wr == 1) mdl_mem[e.idx] = e.wdat;
    e.rdata = last_rd;
    sb.push_back(e);
  endtask

  task automatic init_mem();
    mdl_mem[0] = 32'h11223344;
    mdl_mem[1] = 32'hA0B0C0D0;
    @(negedge clk); load_mem = 1'b1;
    @(negedge clk); load_mem = 1'b0;
  endtask

  // One access with req pulsed for the accepting edge; checks latency,
  // strobe counts, write data, result and the single-cycle done.
  task automatic do_access(input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] d, input string name,
                           input logic release_rst);
    exp_t e;
    int edges, rd, wr;
    logic [31:0] wseen;
    push_exp(o, a, d);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    req = 1'b1; op = o; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; op = LW; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    edges = 0; rd = 0; wr = 0; wseen = 32'h0;
    while (done !== 1'b1 && edges < 20) begin
      if (mem_read === 1'b1) rd++;
      if (mem_write === 1'b1) begin wr++; wseen = mem_write_data; end
      @(posedge clk); #1;
      edges++;
    end
    e = sb.pop_front();
    n_tests++;
    if (edges != e.lat) begin n_fail++; $display("FAIL %s latency: got %0d edges, want %0d", name, edges, e.lat); end
    n_tests++;
    if (rd != e.rd || wr != e.wr) begin
      n_fail++; $display("FAIL %s strobes: read=%0d write=%0d, want read=%0d write=%0d", name, rd, wr, e.rd, e.wr);
    end
    n_tests++;
    if (err !== e.err || rdata !== e.rdata) begin
      n_fail++; $display("FAIL %s result: err=%b rdata=%h, want err=%b rdata=%h", name, err, rdata, e.err, e.rdata);
    end
    if (e.wr == 1) begin
      n_tests++;
      if (wseen !== e.wdat || tb_mem[e.idx] !== e.wdat) begin
        n_fail++; $display("FAIL %s store: bus=%h mem=%h, want %h", name, wseen, tb_mem[e.idx], e.wdat);
      end
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s after done: done=%b busy=%b, want 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    init_mem();
    #1;
    n_tests++;
    if ({busy, done, err, mem_read, mem_write} !== 5'b0 || rdata !== 32'h0 ||
        mem_write_data !== 32'h0 || mem_address !== '0) begin
      n_fail++;
      $display("FAIL reset state: busy=%b done=%b err=%b rd=%b wr=%b rdata=%h wdat=%h addr=%h, want all 0",
               busy, done, err, mem_read, mem_write, rdata, mem_write_data, mem_address);
    end
    // Reset released on the same negedge the first request is driven.
    do_access(LW, 32'd4, 32'h0, "first_lw4", 1'b1);
  endtask

  task automatic test_loads();
    do_access(LB,  32'd5, 32'h0, "lb5",  1'b0);
    do_access(LBU, 32'd5, 32'h0, "lbu5", 1'b0);
    do_access(LH,  32'd6, 32'h0, "lh6",  1'b0);
    do_access(LHU, 32'd2, 32'h0, "lhu2", 1'b0);
    do_access(LW,  32'd0, 32'h0, "lw0",  1'b0);
    do_access(LB,  32'd0, 32'h0, "lb0",  1'b0);
    do_access(LBU, 32'd7, 32'h0, "lbu7", 1'b0);
    do_access(LH,  32'd4, 32'h0, "lh4",  1'b0);
  endtask

  task automatic test_stores();
    do_access(SB, 32'd1, 32'h0000_00EE, "sb1",   1'b0);
    do_access(LW, 32'd0, 32'h0,         "lw0_sb", 1'b0);
    do_access(SH, 32'd6, 32'h1234_BEEF, "sh6",   1'b0);
    do_access(SH, 32'd4, 32'hFFFF_7A7A, "sh4",   1'b0);
    do_access(SB, 32'd7, 32'hAAAA_AA01, "sb7",   1'b0);
    do_access(SW, 32'd0, 32'hDEAD_BEEF, "sw0",   1'b0);
    do_access(LH, 32'd4, 32'h0,         "lh4_st", 1'b0);
    do_access(LW, 32'd4, 32'h0,         "lw4_st", 1'b0);
  endtask

  task automatic test_errors();
    do_access(SH,  32'd3,  32'h0000_5555, "sh3_err",  1'b0);
    do_access(LW,  32'd8,  32'h0,         "lw8_err",  1'b0);
    do_access(LW,  32'd2,  32'h0,         "lw2_err",  1'b0);
    do_access(LHU, 32'd1,  32'h0,         "lhu1_err", 1'b0);
    do_access(SB,  32'd9,  32'h0000_0077, "sb9_err",  1'b0);
    do_access(SW,  32'h8000_0000, 32'h1,  "sw_high_err", 1'b0);
  endtask

  task automatic test_reset_abort();
    int wr_before;
    init_mem();
    wr_before = wr_total;
    @(negedge clk);
    req = 1'b1; op = SB; addr = 32'd1; wdata = 32'h0000_00EE;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_read !== 1'b0 || busy !== 1'b0 || mem_write !== 1'b0 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL abort reset: rd=%b busy=%b wr=%b rdata=%h, want 0 0 0 0", mem_read, busy, mem_write, rdata);
    end
    last_rd = 32'h0;
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (wr_total != wr_before || tb_mem[0] !== 32'h11223344) begin
      n_fail++; $display("FAIL abort no write: writes=%0d mem0=%h, want %0d 11223344", wr_total - wr_before, tb_mem[0], 0);
    end
    do_access(LW, 32'd0, 32'h0, "lw0_after_abort", 1'b0);
  endtask

  // req held high; op/addr swapped to an illegal request while busy so a
  // queued or mid-access accept would show up as an extra or wrong completion.
  task automatic test_back_to_back();
    logic [2:0]  ops [5];
    logic [31:0] adr [5];
    logic [31:0] dat [5];
    exp_t e;
    int cyc, dones_before;
    ops = '{LW, SW, LW, SW, LW};
    adr = '{32'd0, 32'd4, 32'd4, 32'd0, 32'd0};
    dat = '{32'h0, 32'h5A5A_1234, 32'h0, 32'hCAFE_F00D, 32'h0};
    init_mem();
    dones_before = done_total;
    @(negedge clk);
    req = 1'b1; op = ops[0]; addr = adr[0]; wdata = dat[0];
    push_exp(ops[0], adr[0], dat[0]);
    for (int k = 0; k < 5; k++) begin
      cyc = 0;
      while (busy !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
      op = LW; addr = 32'd8; wdata = 32'h0;
      while (done !== 1'b1 && cyc < 30) begin @(negedge clk); cyc++; end
      e = sb.pop_front();
      n_tests++;
      if (done !== 1'b1 || err !== e.err || rdata !== e.rdata) begin
        n_fail++; $display("FAIL b2b[%0d]: done=%b err=%b rdata=%h, want 1 %b %h", k, done, err, rdata, e.err, e.rdata);
      end
      if (k < 4) begin
        op = ops[k+1]; addr = adr[k+1]; wdata = dat[k+1];
        push_exp(ops[k+1], adr[k+1], dat[k+1]);
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b[%0d] idle gap: busy=%b, want 0", k, busy); end
    end
    repeat (8) @(negedge clk);
    n_tests++;
    if (done_total - dones_before != 5 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b done count: got %0d busy=%b, want 5 busy=0", done_total - dones_before, busy);
    end
    n_tests++;
    if (tb_mem[0] !== 32'hCAFE_F00D || tb_mem[1] !== 32'h5A5A_1234) begin
      n_fail++; $display("FAIL b2b memory: %h %h, want cafef00d 5a5a1234", tb_mem[0], tb_mem[1]);
    end
  endtask

  task automatic test_invariants();
    n_tests++;
    if (overlap_cnt != 0) begin n_fail++; $display("FAIL strobe overlap: %0d cycles, want 0", overlap_cnt); end
    n_tests++;
    if (addr_change != 0) begin n_fail++; $display("FAIL address stability: %0d changes while busy, want 0", addr_change); end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard leftover: %0d entries, want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a scenario wedges outside its own bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
